// File: rtl/knn_result_axis_packer_pkg.sv
// Shared types and sizing helpers for the KNN result stream packer.
// Holds the output FSM state encoding and the pointer/counter width helpers.
// No logic of its own; imported by the buffer and the top.
package knn_result_axis_packer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_NAME  = 2'b01,
        S_VALUE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointers need at least one bit even for a single-entry store.
    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/knn_result_axis_packer_result_buffer.sv
// K-entry circular store of {name, value} results with push, pop and head read.
// Latency: a push is readable at the head the cycle after its edge; head read is combinational from state.
// Backpressure: none internally; the caller never pushes when full and only pops when non-empty.
module knn_result_axis_packer_result_buffer
    import knn_result_axis_packer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int K          = 1,
    localparam int PTR_W      = ptr_width(K),
    localparam int CNT_W      = clog2(K + 1)
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [31:0]           push_name,
    input  logic [DATA_WIDTH-1:0] push_value,
    input  logic                  pop,
    output logic [CNT_W-1:0]      occ,
    output logic [31:0]           head_name,
    output logic [DATA_WIDTH-1:0] head_value
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(K - 1);

    logic [31:0]           name_mem  [K];
    logic [DATA_WIDTH-1:0] value_mem [K];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Entry storage: written at the write pointer, never cleared by reset.
    always_ff @(posedge mclk) begin
        if (push) begin
            name_mem[wr_ptr]  <= push_name;
            value_mem[wr_ptr] <= push_value;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave occ unchanged.
    always_ff @(posedge mclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    assign head_name  = name_mem[rd_ptr];
    assign head_value = value_mem[rd_ptr];

endmodule

// File: rtl/knn_result_axis_packer.sv
// Captures K single-cycle KNN results and replays them as name/value AXI4-Stream beats with tlast.
// Latency: result captured at edge n drives tvalid from the cycle after edge n+1; 1 beat/cycle when streaming.
// Backpressure: the core side never stalls (extra results set overflow); the stream side honours tready fully.
module knn_result_axis_packer
    import knn_result_axis_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 1
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  AXIS_out_wr_en,
    input  logic [31:0]           dataNameOut,
    input  logic [DATA_WIDTH-1:0] dataValueOut,
    output logic                  M_AXIS_tvalid,
    input  logic                  M_AXIS_tready,
    output logic [31:0]           M_AXIS_tdata,
    output logic                  M_AXIS_tlast,
    output logic                  done,
    output logic                  overflow
);

    localparam int               CNT_W    = clog2(K + 1);
    localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(K);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

    state_t                state;
    logic [CNT_W-1:0]      cap_cnt;
    logic [CNT_W-1:0]      sent_cnt;
    logic [CNT_W-1:0]      occ;
    logic [31:0]           head_name;
    logic [DATA_WIDTH-1:0] head_value;
    logic                  push;
    logic                  pop;
    logic                  more_pending;

    // Only the first K results of a query are kept; the buffer can never be full while cap_cnt < K.
    assign push = AXIS_out_wr_en && (cap_cnt != K_CNT);
    assign pop  = (state == S_VALUE) && M_AXIS_tready;

    // Entry left after the pop, counting a result arriving in the same cycle.
    assign more_pending = (occ > CNT_W'(1)) || push;

    knn_result_axis_packer_result_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K)
    ) u_result_buffer (
        .mclk       (mclk),
        .reset      (reset),
        .push       (push),
        .push_name  (dataNameOut),
        .push_value (dataValueOut),
        .pop        (pop),
        .occ        (occ),
        .head_name  (head_name),
        .head_value (head_value)
    );

    // Capture counter and sticky overflow for results beyond the K-th.
    always_ff @(posedge mclk) begin
        if (reset) begin
            cap_cnt  <= '0;
            overflow <= 1'b0;
        end else if (AXIS_out_wr_en) begin
            if (cap_cnt != K_CNT) begin
                cap_cnt <= cap_cnt + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Output FSM: name beat then value beat per result; tvalid/tlast/done registered.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state         <= S_IDLE;
            sent_cnt      <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (occ != '0) begin
                        state         <= S_NAME;
                        M_AXIS_tvalid <= 1'b1;
                    end
                end
                S_NAME: begin
                    if (M_AXIS_tready) begin
                        state        <= S_VALUE;
                        M_AXIS_tlast <= (sent_cnt == LAST_CNT);
                    end
                end
                S_VALUE: begin
                    if (M_AXIS_tready) begin
                        sent_cnt     <= sent_cnt + 1'b1;
                        M_AXIS_tlast <= 1'b0;
                        if (sent_cnt == LAST_CNT) begin
                            state         <= S_DONE;
                            M_AXIS_tvalid <= 1'b0;
                            done          <= 1'b1;
                        end else if (more_pending) begin
                            state <= S_NAME;
                        end else begin
                            state         <= S_IDLE;
                            M_AXIS_tvalid <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Beat data is selected from registered state and the buffer head, so it holds while stalled.
    always_comb begin
        M_AXIS_tdata = '0;
        case (state)
            S_NAME:  M_AXIS_tdata = head_name;
            S_VALUE: M_AXIS_tdata = 32'(head_value);
            default: M_AXIS_tdata = '0;
        endcase
    end

endmodule

// File: tb/tb_knn_result_axis_packer.sv
// Self-checking bench: three packers (K=4/32b, K=1/16b, K=2/32b) share one stimulus stream.
// Each instance is checked every cycle against a beat-queue reference model.
// tready is driven by the bench; outputs are sampled 1 time unit after the rising edge.
module tb_knn_result_axis_packer;

    localparam int NI = 3;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] name_in = '0;
    logic [31:0] value_in = '0;

    logic        tv [NI];
    logic [31:0] td [NI];
    logic        tl [NI];
    logic        dn [NI];
    logic        ov [NI];

    always #5 mclk = ~mclk;

    knn_result_axis_packer #(.DATA_WIDTH(32), .K(4)) u_k4 (
        .mclk(mclk), .reset(reset), .AXIS_out_wr_en(wr_en),
        .dataNameOut(name_in), .dataValueOut(value_in),
        .M_AXIS_tvalid(tv[0]), .M_AXIS_tready(tready), .M_AXIS_tdata(td[0]),
        .M_AXIS_tlast(tl[0]), .done(dn[0]), .overflow(ov[0])
    );

    knn_result_axis_packer #(.DATA_WIDTH(16), .K(1)) u_k1 (
        .mclk(mclk), .reset(reset), .AXIS_out_wr_en(wr_en),
        .dataNameOut(name_in), .dataValueOut(value_in[15:0]),
        .M_AXIS_tvalid(tv[1]), .M_AXIS_tready(tready), .M_AXIS_tdata(td[1]),
        .M_AXIS_tlast(tl[1]), .done(dn[1]), .overflow(ov[1])
    );

    knn_result_axis_packer #(.DATA_WIDTH(32), .K(2)) u_k2 (
        .mclk(mclk), .reset(reset), .AXIS_out_wr_en(wr_en),
        .dataNameOut(name_in), .dataValueOut(value_in),
        .M_AXIS_tvalid(tv[2]), .M_AXIS_tready(tready), .M_AXIS_tdata(td[2]),
        .M_AXIS_tlast(tl[2]), .done(dn[2]), .overflow(ov[2])
    );

    // Reference model: per instance, the list of beats still owed to the consumer.
    int          kk        [NI];
    logic [31:0] vmask     [NI];
    logic [31:0] exp_dat   [NI][16];
    logic        exp_last  [NI][16];
    int          q_wr      [NI];
    int          q_rd      [NI];
    int          cap       [NI];
    int          acc       [NI];
    int          obs_beats [NI];
    logic        ovf_exp   [NI];
    logic        done_exp  [NI];
    logic        ne_now    [NI];
    logic        ne_before [NI];
    logic        vld_model [NI];

    logic [31:0] stim_name [8];
    logic [31:0] stim_val  [8];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s (K=%0d) cycle %0d: observed %0h expected %0h", tag, kk[inst], cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            q_wr[i] = 0; q_rd[i] = 0; cap[i] = 0; acc[i] = 0; obs_beats[i] = 0;
            ovf_exp[i] = 1'b0; done_exp[i] = 1'b0;
            ne_now[i] = 1'b0; ne_before[i] = 1'b0; vld_model[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; tready = 1'b0;
        @(posedge mclk); #1; cyc++;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            chk("reset_tvalid", i, tv[i], 0);
            chk("reset_tdata", i, td[i], 0);
            chk("reset_tlast", i, tl[i], 0);
            chk("reset_done", i, dn[i], 0);
            chk("reset_overflow", i, ov[i], 0);
        end
    endtask

    // One clock cycle: apply inputs, advance the model, then check all outputs after the edge.
    task automatic step(input logic pulse, input logic [31:0] nm, input logic [31:0] vl, input logic rdy);
        wr_en = pulse; name_in = nm; value_in = vl; tready = rdy;
        for (int i = 0; i < NI; i++) begin
            if (tv[i] && rdy) obs_beats[i]++;
            if (vld_model[i] && rdy && (q_rd[i] != q_wr[i])) begin
                q_rd[i]++;
                acc[i]++;
                if (acc[i] == 2 * kk[i]) done_exp[i] = 1'b1;
            end
            if (pulse) begin
                if (cap[i] < kk[i]) begin
                    exp_dat[i][q_wr[i]] = nm;
                    exp_last[i][q_wr[i]] = 1'b0;
                    q_wr[i]++;
                    exp_dat[i][q_wr[i]] = vl & vmask[i];
                    exp_last[i][q_wr[i]] = (cap[i] == kk[i] - 1);
                    q_wr[i]++;
                    cap[i]++;
                end else begin
                    ovf_exp[i] = 1'b1;
                end
            end
            ne_before[i] = ne_now[i];
            ne_now[i] = (q_wr[i] != q_rd[i]);
        end
        @(posedge mclk); #1; cyc++;
        wr_en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            // A beat is offered once the owed-beat list has been non-empty for two consecutive cycles.
            vld_model[i] = ne_now[i] && ne_before[i];
            chk("tvalid", i, tv[i], vld_model[i]);
            if (vld_model[i]) begin
                chk("tdata", i, td[i], exp_dat[i][q_rd[i]]);
                chk("tlast", i, tl[i], exp_last[i][q_rd[i]]);
            end else begin
                chk("tlast_idle", i, tl[i], 0);
            end
            chk("done", i, dn[i], done_exp[i]);
            chk("overflow", i, ov[i], ovf_exp[i]);
        end
    endtask

    // mode 0: tready=1; mode 1: tready=0 for 10 cycles then toggling 1/0; mode 2: random.
    task automatic play(input int n, input int gap, input int mode, input int tail);
        int   total;
        int   idx;
        logic p;
        logic r;
        total = n * (gap + 1) + tail;
        for (int t = 0; t < total; t++) begin
            idx = t / (gap + 1);
            p = ((t % (gap + 1)) == 0) && (idx < n);
            case (mode)
                0:       r = 1'b1;
                1:       r = (t >= 10) && (((t - 10) % 2) == 0);
                default: r = ($urandom_range(3) != 0);
            endcase
            if (p) step(1'b1, stim_name[idx], stim_val[idx], r);
            else   step(1'b0, $urandom, $urandom, r);
        end
        for (int i = 0; i < NI; i++) chk("beat_count", i, obs_beats[i], q_rd[i]);
    endtask

    task automatic load_query1();
        stim_name[0] = 32'd7; stim_val[0] = 32'd100;
        stim_name[1] = 32'd3; stim_val[1] = 32'd250;
        stim_name[2] = 32'd9; stim_val[2] = 32'd260;
        stim_name[3] = 32'd1; stim_val[3] = 32'd400;
    endtask

    task automatic load_random();
        for (int j = 0; j < 8; j++) begin
            stim_name[j] = $urandom;
            stim_val[j]  = $urandom;
        end
    endtask

    initial begin
        int t;
        kk    = '{4, 1, 2};
        vmask = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
        model_reset();

        // Four results back to back, consumer always ready.
        do_reset();
        load_query1();
        play(4, 0, 0, 12);

        // Same query, consumer stalled 10 cycles then alternating.
        do_reset();
        play(4, 0, 1, 30);

        // Fifth pulse (2,5) must be dropped and flagged.
        do_reset();
        load_query1();
        stim_name[4] = 32'd2; stim_val[4] = 32'd5;
        play(5, 0, 0, 12);

        // Single result with an all-ones 16-bit value.
        do_reset();
        stim_name[0] = 32'h0000_0042; stim_val[0] = 32'h0000_FFFF;
        play(1, 0, 0, 8);

        // Reset while the second value beat of the K=4 query is stalled, then a fresh query.
        do_reset();
        load_random();
        t = 0;
        while (!((q_rd[0] == 3) && vld_model[0]) && (t < 20)) begin
            if (t < 4) step(1'b1, stim_name[t], stim_val[t], (q_rd[0] < 3));
            else       step(1'b0, 32'h0, 32'h0, (q_rd[0] < 3));
            t++;
        end
        step(1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();
        load_random();
        play(4, 0, 2, 30);

        // Two results 20 cycles apart; stream goes idle in between.
        do_reset();
        load_random();
        play(2, 19, 0, 10);

        // Random queries: count, spacing, data and tready pattern.
        for (int round = 0; round < 4; round++) begin
            do_reset();
            load_random();
            play($urandom_range(6, 1), $urandom_range(3), 2, 40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
